// File: rtl/aes_cipher_drain_if.sv
// Word stream from the AES drain stage to a back-pressured consumer.
// Master drives valid/data/last; slave returns ready.
interface aes_cipher_drain_if #(
  parameter int WORD_W = 32
);
  logic              word_valid_out;
  logic              word_ready_in;
  logic [WORD_W-1:0] word_out;
  logic              word_last_out;

  modport master (
    output word_valid_out,
    output word_out,
    output word_last_out,
    input  word_ready_in
  );

  modport slave (
    input  word_valid_out,
    input  word_out,
    input  word_last_out,
    output word_ready_in
  );
endinterface

// File: rtl/aes_cipher_drain.sv
// Buffers AES ciphertext blocks captured on ready_in rising edges and streams them MS word first.
// Optional macro AES_DRAIN_BYTESWAP_EN: byte-reverse each output word (little-endian bus).
module aes_cipher_drain #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready_in,
  input  logic [127:0]         cipher_in,
  aes_cipher_drain_if.master   word_if,
  output logic                 full_out,
  output logic                 ovf_out
);
  localparam int NW = 128 / WORD_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NW);

  logic              ready_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ovf_q, ovf_d;
  logic [127:0]      mem_q [DEPTH];

  logic              capture, full, valid, xfer, pop, accept;
  logic [127:0]      head_blk;
  logic [WORD_W-1:0] slice [NW];
  logic [WORD_W-1:0] word_sel, word_fmt;

  assign capture = ready_in & ~ready_q;
  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign xfer    = valid & word_if.word_ready_in;
  assign pop     = xfer & (idx_q == IW'(NW - 1));
  // A last-word pop frees a slot in the same cycle, so a capture while full is still accepted.
  assign accept  = capture & (~full | pop);

  assign wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(accept) - CW'(pop);
  assign ovf_d    = ovf_q | (capture & full & ~pop);

  always_comb begin
    idx_d = idx_q;
    if (pop) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // The next head may be the block being written this very edge (queue empty, or count==1 with pop).
  assign head_blk = (accept && (rd_ptr_d == wr_ptr_q)) ? cipher_in : mem_q[rd_ptr_d];

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_slice
      assign slice[gi] = head_blk[127 - WORD_W*gi -: WORD_W];
    end
  endgenerate

  assign word_sel = slice[idx_d];

`ifdef AES_DRAIN_BYTESWAP_EN
  generate
    for (gi = 0; gi < WORD_W/8; gi++) begin : g_swap
      assign word_fmt[8*gi +: 8] = word_sel[WORD_W-8-8*gi +: 8];
    end
  endgenerate
`else
  assign word_fmt = word_sel;
`endif

  assign word_d = (count_d != '0) ? word_fmt : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= cipher_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q  <= ready_in;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      ovf_q    <= ovf_d;
    end
  end

  assign word_if.word_valid_out = valid;
  assign word_if.word_out       = word_q;
  assign word_if.word_last_out  = valid & (idx_q == IW'(NW - 1));
  assign full_out               = full;
  assign ovf_out                = ovf_q;
endmodule

// File: tb/tb_aes_cipher_drain.sv
// Scoreboard bench for aes_cipher_drain: stimulus pushes expected words, a negedge monitor checks them.
module tb_aes_cipher_drain;
  localparam int WORD_W = 32;
  localparam int NW     = 4;
  localparam logic [127:0] B1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B3 = 128'hdeadbeef0badf00dcafebabe13579bdf;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready_in;
  logic [127:0] cipher_in;
  logic         full_out;
  logic         ovf_out;

  aes_cipher_drain_if #(.WORD_W(WORD_W)) wif ();

  aes_cipher_drain #(.WORD_W(WORD_W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready_in  (ready_in),
    .cipher_in (cipher_in),
    .word_if   (wif),
    .full_out  (full_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef AES_DRAIN_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return fmt(b[127-32*i -: 32]);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push_block(input logic [127:0] b);
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.w    = word_of(b, i);
      e.last = (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a transfer is decided at the next rising edge, so check at the falling edge before it.
  always @(negedge clk) begin
    if (rst && wif.word_valid_out) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", wif.word_out);
      end else if (wif.word_ready_in) begin
        chk("xfer_word", 128'(wif.word_out), 128'(exp_q[0].w));
        chk("xfer_last", 128'(wif.word_last_out), 128'(exp_q[0].last));
        void'(exp_q.pop_front());
      end else begin
        chk("stall_word", 128'(wif.word_out), 128'(exp_q[0].w));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [127:0] b, input bit expect_kept);
    cipher_in = b;
    ready_in  = 1'b1;
    if (expect_kept) push_block(b);
    tick();
    ready_in = 1'b0;
    tick();
  endtask

  task automatic wait_empty(input string name, input int maxc);
    int c = 0;
    while (wif.word_valid_out && c < maxc) begin
      tick();
      c++;
    end
    chk(name, 128'(wif.word_valid_out), 128'(0));
    chk({name, "_sb"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_valid"}, 128'(wif.word_valid_out), 128'(0));
    chk({name, "_word"},  128'(wif.word_out),       128'(0));
    chk({name, "_last"},  128'(wif.word_last_out),  128'(0));
    chk({name, "_full"},  128'(full_out),           128'(0));
  endtask

  task automatic do_reset;
    wif.word_ready_in = 1'b0;
    ready_in          = 1'b0;
    rst               = 1'b0;
    #1;
    check_idle_outputs("rst");
    chk("rst_ovf", 128'(ovf_out), 128'(0));
    exp_q.delete();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with ready_in high; release yields exactly one capture.
    rst               = 1'b0;
    ready_in          = 1'b1;
    cipher_in         = B1;
    wif.word_ready_in = 1'b0;
    #12;
    check_idle_outputs("t1_reset");
    chk("t1_reset_ovf", 128'(ovf_out), 128'(0));
    rst = 1'b1;
    push_block(B1);
    #1;
    chk("t1_pre_capture_valid", 128'(wif.word_valid_out), 128'(0));
    tick();
    chk("t1_latency_valid", 128'(wif.word_valid_out), 128'(1));
    chk("t1_first_word", 128'(wif.word_out), 128'(word_of(B1, 0)));
    chk("t1_first_last", 128'(wif.word_last_out), 128'(0));
    repeat (3) tick();
    chk("t1_held_level_one_capture_full", 128'(full_out), 128'(0));

    // Free-flowing drain: four words on four consecutive cycles.
    wif.word_ready_in = 1'b1;
    repeat (NW) tick();
    chk("t2_drained_in_4", 128'(wif.word_valid_out), 128'(0));
    chk("t2_sb_empty", 128'(exp_q.size()), 128'(0));
    ready_in          = 1'b0;
    wif.word_ready_in = 1'b0;
    tick();

    // Toggling ready: four transfers in eight cycles, words held while stalled.
    cap(B1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wif.word_ready_in = (k % 2 == 0);
      tick();
    end
    wif.word_ready_in = 1'b0;
    chk("t3_drained_in_8", 128'(wif.word_valid_out), 128'(0));
    chk("t3_sb_empty", 128'(exp_q.size()), 128'(0));

    // Overflow: third capture into a full buffer is dropped.
    cap(B1, 1'b1);
    chk("t4_not_full_1", 128'(full_out), 128'(0));
    cap(B2, 1'b1);
    chk("t4_full_2", 128'(full_out), 128'(1));
    chk("t4_no_ovf_2", 128'(ovf_out), 128'(0));
    cap(B3, 1'b0);
    chk("t4_ovf_3", 128'(ovf_out), 128'(1));
    chk("t4_full_3", 128'(full_out), 128'(1));
    wif.word_ready_in = 1'b1;
    wait_empty("t4_drain", 20);
    chk("t4_ovf_sticky", 128'(ovf_out), 128'(1));
    wif.word_ready_in = 1'b0;

    // Capture coincides with the last-word pop while full.
    do_reset();
    cap(B1, 1'b1);
    cap(B2, 1'b1);
    chk("t5_full", 128'(full_out), 128'(1));
    wif.word_ready_in = 1'b1;
    repeat (3) tick();
    cipher_in = B3;
    ready_in  = 1'b1;
    push_block(B3);
    tick();
    ready_in = 1'b0;
    chk("t5_full_kept", 128'(full_out), 128'(1));
    chk("t5_no_ovf", 128'(ovf_out), 128'(0));
    wait_empty("t5_drain", 20);
    chk("t5_no_ovf_end", 128'(ovf_out), 128'(0));
    wif.word_ready_in = 1'b0;

    // Reset mid-drain, then a fresh block restarts at word 0.
    do_reset();
    cap(B1, 1'b1);
    wif.word_ready_in = 1'b1;
    repeat (2) tick();
    chk("t6_sb_two_left", 128'(exp_q.size()), 128'(2));
    wif.word_ready_in = 1'b0;
    rst               = 1'b0;
    #1;
    check_idle_outputs("t6_async_rst");
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_empty_after_rst", 128'(wif.word_valid_out), 128'(0));
    cap(B1, 1'b1);
    chk("t6_restart_word0", 128'(wif.word_out), 128'(word_of(B1, 0)));
    wif.word_ready_in = 1'b1;
    wait_empty("t6_drain", 20);
    wif.word_ready_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
